// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: captures regfile operands, immediate, PC and control,
// inserts a bubble on load-use hazards or flush, forwards MEM results, counts stalls.
module id_ex_stage #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CTRLW = 8,
   parameter int unsigned CNTW  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [4:0]       id_rs1addr,
   input  logic [4:0]       id_rs2addr,
   input  logic             id_rs1_used,
   input  logic             id_rs2_used,
   input  logic [4:0]       id_rdaddr,
   input  logic [XLEN-1:0]  rs1o,
   input  logic [XLEN-1:0]  rs2o,
   input  logic [XLEN-1:0]  id_imm,
   input  logic [CTRLW-1:0] id_ctrl,
   input  logic             id_regwr,
   input  logic             id_memrd,
   input  logic             id_memwr,
   input  logic             mem_regwr,
   input  logic [4:0]       mem_rdaddr,
   input  logic [XLEN-1:0]  mem_result,
   input  logic             flush,
   output logic             stall_if,
   output logic             ex_valid,
   output logic [XLEN-1:0]  ex_pc,
   output logic [XLEN-1:0]  ex_imm,
   output logic [XLEN-1:0]  ex_rs1val,
   output logic [XLEN-1:0]  ex_rs2val,
   output logic [4:0]       ex_rs1addr,
   output logic [4:0]       ex_rs2addr,
   output logic [4:0]       ex_rdaddr,
   output logic [CTRLW-1:0] ex_ctrl,
   output logic             ex_regwr,
   output logic             ex_memrd,
   output logic             ex_memwr,
   output logic [CNTW-1:0]  stall_cnt
);

   logic            hz;
   logic            rs1_match;
   logic            rs2_match;
   logic            fwd1;
   logic            fwd2;
   logic            bubble;
   logic            cnt_sat;
   logic [XLEN-1:0] rs1_fwd;
   logic [XLEN-1:0] rs2_fwd;

   // Load in EX whose rd is needed by ID: value not available until after MEM.
   always_comb begin
      rs1_match = id_rs1_used & (id_rs1addr == ex_rdaddr);
      rs2_match = id_rs2_used & (id_rs2addr == ex_rdaddr);
      hz        = ex_valid & ex_memrd & (ex_rdaddr != 5'd0) & id_valid &
                  (rs1_match | rs2_match);
   end

   assign stall_if = hz & ~flush;
   assign bubble   = flush | hz;

   // WB producers already land on rs*o (regfile writes on negedge), so only MEM is bypassed.
   always_comb begin
      fwd1    = mem_regwr & (mem_rdaddr != 5'd0) & (mem_rdaddr == id_rs1addr);
      fwd2    = mem_regwr & (mem_rdaddr != 5'd0) & (mem_rdaddr == id_rs2addr);
      rs1_fwd = fwd1 ? mem_result : rs1o;
      rs2_fwd = fwd2 ? mem_result : rs2o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid   <= 1'b0;
         ex_pc      <= '0;
         ex_imm     <= '0;
         ex_rs1val  <= '0;
         ex_rs2val  <= '0;
         ex_rs1addr <= 5'd0;
         ex_rs2addr <= 5'd0;
         ex_rdaddr  <= 5'd0;
         ex_ctrl    <= '0;
         ex_regwr   <= 1'b0;
         ex_memrd   <= 1'b0;
         ex_memwr   <= 1'b0;
      end else if (bubble) begin
         // Data fields hold; only the qualifying bits are cleared.
         ex_valid <= 1'b0;
         ex_regwr <= 1'b0;
         ex_memrd <= 1'b0;
         ex_memwr <= 1'b0;
      end else begin
         ex_valid   <= id_valid;
         ex_pc      <= id_pc;
         ex_imm     <= id_imm;
         ex_rs1val  <= rs1_fwd;
         ex_rs2val  <= rs2_fwd;
         ex_rs1addr <= id_rs1addr;
         ex_rs2addr <= id_rs2addr;
         ex_rdaddr  <= id_rdaddr;
         ex_ctrl    <= id_ctrl;
         ex_regwr   <= id_regwr & id_valid;
         ex_memrd   <= id_memrd & id_valid;
         ex_memwr   <= id_memwr & id_valid;
      end
   end

   assign cnt_sat = &stall_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (stall_if && !cnt_sat) begin
         stall_cnt <= stall_cnt + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a second CNTW=4 instance checks saturation.
module tb_id_ex_stage;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CTRLW = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             id_valid;
   logic [XLEN-1:0]  id_pc;
   logic [4:0]       id_rs1addr;
   logic [4:0]       id_rs2addr;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [4:0]       id_rdaddr;
   logic [XLEN-1:0]  rs1o;
   logic [XLEN-1:0]  rs2o;
   logic [XLEN-1:0]  id_imm;
   logic [CTRLW-1:0] id_ctrl;
   logic             id_regwr;
   logic             id_memrd;
   logic             id_memwr;
   logic             mem_regwr;
   logic [4:0]       mem_rdaddr;
   logic [XLEN-1:0]  mem_result;
   logic             flush;

   logic             stall_if;
   logic             ex_valid;
   logic [XLEN-1:0]  ex_pc;
   logic [XLEN-1:0]  ex_imm;
   logic [XLEN-1:0]  ex_rs1val;
   logic [XLEN-1:0]  ex_rs2val;
   logic [4:0]       ex_rs1addr;
   logic [4:0]       ex_rs2addr;
   logic [4:0]       ex_rdaddr;
   logic [CTRLW-1:0] ex_ctrl;
   logic             ex_regwr;
   logic             ex_memrd;
   logic             ex_memwr;
   logic [15:0]      stall_cnt;

   logic             s_stall_if;
   logic             s_ex_valid;
   logic [XLEN-1:0]  s_ex_pc;
   logic [XLEN-1:0]  s_ex_imm;
   logic [XLEN-1:0]  s_ex_rs1val;
   logic [XLEN-1:0]  s_ex_rs2val;
   logic [4:0]       s_ex_rs1addr;
   logic [4:0]       s_ex_rs2addr;
   logic [4:0]       s_ex_rdaddr;
   logic [CTRLW-1:0] s_ex_ctrl;
   logic             s_ex_regwr;
   logic             s_ex_memrd;
   logic             s_ex_memwr;
   logic [3:0]       s_stall_cnt;

   int n_pass  = 0;
   int n_total = 0;
   int exp_cnt = 0;

   always #5 clk = ~clk;

   id_ex_stage #(.XLEN(XLEN), .CTRLW(CTRLW), .CNTW(16)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .id_rdaddr(id_rdaddr), .rs1o(rs1o), .rs2o(rs2o),
      .id_imm(id_imm), .id_ctrl(id_ctrl), .id_regwr(id_regwr), .id_memrd(id_memrd),
      .id_memwr(id_memwr), .mem_regwr(mem_regwr), .mem_rdaddr(mem_rdaddr),
      .mem_result(mem_result), .flush(flush), .stall_if(stall_if), .ex_valid(ex_valid),
      .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1val(ex_rs1val), .ex_rs2val(ex_rs2val),
      .ex_rs1addr(ex_rs1addr), .ex_rs2addr(ex_rs2addr), .ex_rdaddr(ex_rdaddr),
      .ex_ctrl(ex_ctrl), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr),
      .stall_cnt(stall_cnt)
   );

   id_ex_stage #(.XLEN(XLEN), .CTRLW(CTRLW), .CNTW(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1addr(id_rs1addr), .id_rs2addr(id_rs2addr), .id_rs1_used(id_rs1_used),
      .id_rs2_used(id_rs2_used), .id_rdaddr(id_rdaddr), .rs1o(rs1o), .rs2o(rs2o),
      .id_imm(id_imm), .id_ctrl(id_ctrl), .id_regwr(id_regwr), .id_memrd(id_memrd),
      .id_memwr(id_memwr), .mem_regwr(mem_regwr), .mem_rdaddr(mem_rdaddr),
      .mem_result(mem_result), .flush(flush), .stall_if(s_stall_if),
      .ex_valid(s_ex_valid), .ex_pc(s_ex_pc), .ex_imm(s_ex_imm),
      .ex_rs1val(s_ex_rs1val), .ex_rs2val(s_ex_rs2val), .ex_rs1addr(s_ex_rs1addr),
      .ex_rs2addr(s_ex_rs2addr), .ex_rdaddr(s_ex_rdaddr), .ex_ctrl(s_ex_ctrl),
      .ex_regwr(s_ex_regwr), .ex_memrd(s_ex_memrd), .ex_memwr(s_ex_memwr),
      .stall_cnt(s_stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      id_valid    = 1'b0;
      id_pc       = '0;
      id_rs1addr  = 5'd0;
      id_rs2addr  = 5'd0;
      id_rs1_used = 1'b0;
      id_rs2_used = 1'b0;
      id_rdaddr   = 5'd0;
      rs1o        = '0;
      rs2o        = '0;
      id_imm      = '0;
      id_ctrl     = '0;
      id_regwr    = 1'b0;
      id_memrd    = 1'b0;
      id_memwr    = 1'b0;
      mem_regwr   = 1'b0;
      mem_rdaddr  = 5'd0;
      mem_result  = '0;
      flush       = 1'b0;
   endtask

   task automatic set_instr(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                            input logic [4:0] rd, input logic ld, input logic wr);
      id_valid    = 1'b1;
      id_pc       = pc;
      id_rs1addr  = r1;
      id_rs2addr  = r2;
      id_rs1_used = 1'b1;
      id_rs2_used = 1'b1;
      id_rdaddr   = rd;
      id_memrd    = ld;
      id_regwr    = wr;
      id_memwr    = 1'b0;
   endtask

   task automatic test_reset();
      set_idle();
      rst_n = 1'b0;
      #12;
      n_total++;
      if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_rs1val !== 32'h0 || ex_ctrl !== 8'h0)
         $display("FAIL reset_regs: valid=%0b pc=%h rs1val=%h ctrl=%h want all 0",
                  ex_valid, ex_pc, ex_rs1val, ex_ctrl);
      else n_pass++;
      n_total++;
      if (stall_cnt !== 16'd0 || stall_if !== 1'b0)
         $display("FAIL reset_cnt: cnt=%0d stall_if=%0b want 0/0", stall_cnt, stall_if);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_passthrough();
      set_instr(32'h100, 5'd1, 5'd2, 5'd4, 1'b0, 1'b1);
      rs1o    = 32'd5;
      rs2o    = 32'd7;
      id_imm  = 32'h20;
      id_ctrl = 8'hA5;
      #1;
      n_total++;
      if (stall_if !== 1'b0) $display("FAIL pass_nostall: got %0b want 0", stall_if);
      else n_pass++;
      tick();
      n_total++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h100 || ex_imm !== 32'h20 || ex_regwr !== 1'b1)
         $display("FAIL pass_fields: valid=%0b pc=%h imm=%h regwr=%0b want 1/100/20/1",
                  ex_valid, ex_pc, ex_imm, ex_regwr);
      else n_pass++;
      n_total++;
      if (ex_rs1val !== 32'd5 || ex_rs2val !== 32'd7 || ex_rdaddr !== 5'd4 ||
          ex_rs1addr !== 5'd1 || ex_rs2addr !== 5'd2 || ex_ctrl !== 8'hA5)
         $display("FAIL pass_ops: rs1=%0d rs2=%0d rd=%0d a1=%0d a2=%0d ctrl=%h want 5/7/4/1/2/a5",
                  ex_rs1val, ex_rs2val, ex_rdaddr, ex_rs1addr, ex_rs2addr, ex_ctrl);
      else n_pass++;
   endtask

   task automatic test_load_use();
      set_instr(32'h104, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
      tick();
      set_instr(32'h108, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1);
      #1;
      n_total++;
      if (stall_if !== 1'b1) $display("FAIL lu_stall: got %0b want 1", stall_if);
      else n_pass++;
      tick();
      exp_cnt++;
      n_total++;
      if (ex_valid !== 1'b0 || ex_regwr !== 1'b0 || ex_memrd !== 1'b0 || ex_pc !== 32'h104)
         $display("FAIL lu_bubble: valid=%0b regwr=%0b memrd=%0b pc=%h want 0/0/0/104",
                  ex_valid, ex_regwr, ex_memrd, ex_pc);
      else n_pass++;
      n_total++;
      if (stall_cnt !== 16'(exp_cnt) || stall_if !== 1'b0)
         $display("FAIL lu_cnt: cnt=%0d stall_if=%0b want %0d/0", stall_cnt, stall_if, exp_cnt);
      else n_pass++;
      tick();
      n_total++;
      if (ex_valid !== 1'b1 || ex_pc !== 32'h108 || ex_rdaddr !== 5'd7)
         $display("FAIL lu_enter: valid=%0b pc=%h rd=%0d want 1/108/7", ex_valid, ex_pc, ex_rdaddr);
      else n_pass++;
   endtask

   task automatic test_forward();
      set_instr(32'h10C, 5'd1, 5'd3, 5'd8, 1'b0, 1'b1);
      rs1o       = 32'd9;
      rs2o       = 32'd0;
      mem_regwr  = 1'b1;
      mem_rdaddr = 5'd3;
      mem_result = 32'hDEAD;
      tick();
      n_total++;
      if (ex_rs2val !== 32'hDEAD || ex_rs1val !== 32'd9)
         $display("FAIL fwd_rs2: rs2=%h rs1=%h want dead/9", ex_rs2val, ex_rs1val);
      else n_pass++;
      id_rs1addr = 5'd3;
      id_rs2addr = 5'd4;
      rs2o       = 32'h44;
      tick();
      n_total++;
      if (ex_rs1val !== 32'hDEAD || ex_rs2val !== 32'h44)
         $display("FAIL fwd_rs1: rs1=%h rs2=%h want dead/44", ex_rs1val, ex_rs2val);
      else n_pass++;
      id_rs1addr = 5'd1;
      id_rs2addr = 5'd0;
      rs2o       = 32'd0;
      mem_rdaddr = 5'd0;
      tick();
      n_total++;
      if (ex_rs2val !== 32'd0) $display("FAIL fwd_x0: rs2=%h want 0", ex_rs2val);
      else n_pass++;
      mem_regwr = 1'b0;
   endtask

   task automatic test_flush_hazard();
      set_instr(32'h200, 5'd2, 5'd0, 5'd5, 1'b1, 1'b1);
      tick();
      set_instr(32'h204, 5'd5, 5'd6, 5'd7, 1'b0, 1'b1);
      flush = 1'b1;
      #1;
      n_total++;
      if (stall_if !== 1'b0) $display("FAIL fh_stall: got %0b want 0", stall_if);
      else n_pass++;
      tick();
      n_total++;
      if (ex_valid !== 1'b0 || ex_regwr !== 1'b0 || stall_cnt !== 16'(exp_cnt))
         $display("FAIL fh_bubble: valid=%0b regwr=%0b cnt=%0d want 0/0/%0d",
                  ex_valid, ex_regwr, stall_cnt, exp_cnt);
      else n_pass++;
      flush = 1'b0;
      // Load to x0 must never stall a reader of x0.
      set_instr(32'h208, 5'd2, 5'd0, 5'd0, 1'b1, 1'b1);
      tick();
      set_instr(32'h20C, 5'd0, 5'd0, 5'd9, 1'b0, 1'b1);
      #1;
      n_total++;
      if (stall_if !== 1'b0) $display("FAIL x0_nohz: got %0b want 0", stall_if);
      else n_pass++;
      tick();
   endtask

   task automatic test_reset_midstream();
      set_instr(32'h300, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1);
      id_ctrl = 8'h3C;
      rs1o    = 32'h11;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      exp_cnt = 0;
      n_total++;
      if (ex_valid !== 1'b0 || ex_pc !== 32'h0 || ex_rs1val !== 32'h0 || ex_ctrl !== 8'h0 ||
          ex_regwr !== 1'b0 || stall_cnt !== 16'd0)
         $display("FAIL mid_reset: valid=%0b pc=%h rs1=%h ctrl=%h regwr=%0b cnt=%0d want 0",
                  ex_valid, ex_pc, ex_rs1val, ex_ctrl, ex_regwr, stall_cnt);
      else n_pass++;
      set_idle();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Load whose address base is its own rd: stalls on every other cycle while held in ID.
   task automatic test_saturation();
      set_instr(32'h400, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1);
      id_rs2_used = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i % 2 == 0) exp_cnt++;
         if (i == 30) begin
            n_total++;
            if (s_stall_cnt !== 4'd15 || stall_cnt !== 16'(exp_cnt))
               $display("FAIL sat_reach: cnt4=%0d cnt16=%0d want 15/%0d",
                        s_stall_cnt, stall_cnt, exp_cnt);
            else n_pass++;
         end
      end
      n_total++;
      if (s_stall_cnt !== 4'd15) $display("FAIL sat_hold: cnt4=%0d want 15", s_stall_cnt);
      else n_pass++;
      n_total++;
      if (stall_cnt !== 16'(exp_cnt))
         $display("FAIL sat_wide: cnt16=%0d want %0d", stall_cnt, exp_cnt);
      else n_pass++;
      set_idle();
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_load_use();
      test_forward();
      test_flush_hazard();
      test_reset_midstream();
      test_saturation();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
